conv_encoder_k4: RTL

Rate-1/2 feed-forward convolutional encoder, K=4 (8 trellis states). It produces the coded symbol stream that the Viterbi decoder consumes. It accepts one information bit per cycle over a valid/ready stream and emits one 2-bit symbol per accepted bit. At frame end it optionally appends K-1 zero tail bits so the decoder's traceback starts and ends in state 0.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_encoder_k4_if.sv | 27 ++
 rtl/conv_sym_gen.sv | 26 ++
 rtl/conv_encoder_k4.sv | 124 ++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared trellis definition for the K=4 rate-1/2 convolutional code.
// Used by the encoder and by the decoder branch-metric logic.
//   K      : constraint length
//   G0/G1  : generator polynomials, MSB taps the current input bit
//   SR_W   : encoder shift-register width (K-1)
//   SYM_W  : coded symbol width
package conv_pkg;

   localparam int unsigned K     = 4;
   localparam int unsigned SR_W  = K - 1;
   localparam int unsigned SYM_W = 2;
   localparam int unsigned CNT_W = 2;

   localparam logic [K-1:0] G0 = 4'b1111;
   localparam logic [K-1:0] G1 = 4'b1101;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } enc_state_t;

endpackage

// File: rtl/conv_encoder_k4_if.sv
// Valid/ready bit stream in, valid/ready symbol stream out, plus frame busy.
//   slave  : encoder side (consumes in_*, produces out_*, busy)
//   master : source/sink side
interface conv_encoder_k4_if;
   import conv_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic             in_bit;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [SYM_W-1:0] out_sym;
   logic             out_last;
   logic             busy;

   modport slave (
      input  in_valid, in_bit, in_last, out_ready,
      output in_ready, out_valid, out_sym, out_last, busy
   );

   modport master (
      output in_valid, in_bit, in_last, out_ready,
      input  in_ready, out_valid, out_sym, out_last, busy
   );

endinterface

// File: rtl/conv_sym_gen.sv
// One trellis step: (input bit, state) -> (coded symbol, next state).
//   i_u        : information bit
//   i_r        : state {u(t-1), u(t-2), u(t-3)}
//   o_sym_c    : {parity G0, parity G1}
//   o_r_next_c : state after shifting in i_u
module conv_sym_gen
   import conv_pkg::*;
#(
   parameter logic [K-1:0] P_G0 = G0,
   parameter logic [K-1:0] P_G1 = G1
) (
   input  logic             i_u,
   input  logic [SR_W-1:0]  i_r,
   output logic [SYM_W-1:0] o_sym_c,
   output logic [SR_W-1:0]  o_r_next_c
);

   logic [K-1:0] w_v;

   always_comb begin
      w_v        = {i_u, i_r};
      o_sym_c    = {^(w_v & P_G0), ^(w_v & P_G1)};
      o_r_next_c = {i_u, i_r[SR_W-1:1]};
   end

endmodule

// File: rtl/conv_encoder_k4.sv
// Rate-1/2 K=4 convolutional encoder with optional zero-tail termination.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stream interface (slave side)
//   TERMINATE  : 1 = append K-1 zero tail symbols after in_last
module conv_encoder_k4
   import conv_pkg::*;
#(
   parameter bit TERMINATE = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   conv_encoder_k4_if.slave  bus
);

   enc_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [SR_W-1:0]  r_sr, w_sr_nxt;
   logic [SYM_W-1:0] r_out_sym, w_out_sym_nxt;
   logic             r_out_valid, w_out_valid_nxt;
   logic             r_out_last, w_out_last_nxt;
   logic             r_busy, w_busy_nxt;

   logic             w_load_ok, w_in_ready, w_in_fire, w_u;
   logic [SYM_W-1:0] w_sym;
   logic [SR_W-1:0]  w_r_next;

   // Tail bits are zeros; data bits come straight from the stream.
   assign w_u = (r_state == ST_RUN) ? bus.in_bit : 1'b0;

   conv_sym_gen u_sym_gen (
      .i_u        (w_u),
      .i_r        (r_sr),
      .o_sym_c    (w_sym),
      .o_r_next_c (w_r_next)
   );

   // Output register may reload when empty or being drained this cycle.
   assign w_load_ok  = !r_out_valid || bus.out_ready;
   assign w_in_ready = (r_state == ST_RUN) && w_load_ok && rst_n;
   assign w_in_fire  = bus.in_valid && w_in_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RUN;
         r_cnt       <= '0;
         r_sr        <= '0;
         r_out_sym   <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_sr        <= w_sr_nxt;
         r_out_sym   <= w_out_sym_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_last  <= w_out_last_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   // Next-state and output-register load logic.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_sr_nxt        = r_sr;
      w_out_sym_nxt   = r_out_sym;
      w_out_last_nxt  = r_out_last;
      w_out_valid_nxt = r_out_valid && !bus.out_ready;
      w_busy_nxt      = r_busy;

      // Frame ends when its final symbol transfers; a new first bit
      // accepted in the same cycle sets busy again below.
      if (r_out_valid && bus.out_ready && r_out_last) begin
         w_busy_nxt = 1'b0;
      end

      case (r_state)
         ST_RUN: begin
            if (w_in_fire) begin
               w_out_sym_nxt   = w_sym;
               w_out_valid_nxt = 1'b1;
               w_out_last_nxt  = 1'b0;
               w_busy_nxt      = 1'b1;
               w_sr_nxt        = w_r_next;
               if (bus.in_last) begin
                  if (TERMINATE) begin
                     w_state_nxt = ST_FLUSH;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_out_last_nxt = 1'b1;
                     w_sr_nxt       = '0;
                  end
               end
            end
         end
         ST_FLUSH: begin
            if (w_load_ok) begin
               w_out_sym_nxt   = w_sym;
               w_out_valid_nxt = 1'b1;
               w_out_last_nxt  = 1'b0;
               w_sr_nxt        = w_r_next;
               w_cnt_nxt       = r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(K - 2)) begin
                  w_out_last_nxt = 1'b1;
                  w_state_nxt    = ST_RUN;
                  w_cnt_nxt      = '0;
               end
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_sym   = r_out_sym;
   assign bus.out_last  = r_out_last;
   assign bus.busy      = r_busy;

endmodule
